// File: rtl/fdiv_pkg.sv
// Shared constants and the side-band record that travels alongside the mantissa divider.
package fdiv_pkg;

    localparam int MANT_W    = 24;
    localparam int QUO_W     = 26;
    localparam int FDIV_LAT  = 10;
    localparam int FDIV_TAGW = 4;

    typedef struct packed {
        logic                 v;
        logic [1:0]           id;
        logic [FDIV_TAGW-1:0] tag;
    } fdiv_shadow_t;

endpackage

// File: rtl/fdiv_mantissa.sv
// Fixed-latency, no-stall restoring divider for 1.23 mantissas.
// Quotient is 26 bits with bit 25 as the integer bit; FDIV_LAT register stages.
module fdiv_mantissa
    import fdiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              input_valid,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic              out_valid,
    output logic [QUO_W-1:0]  quotient
);

    localparam int BPS = (QUO_W + FDIV_LAT - 1) / FDIV_LAT;

    typedef struct packed {
        logic              v;
        logic [MANT_W:0]   rem;
        logic [MANT_W-1:0] dvs;
        logic [QUO_W-1:0]  quo;
    } stage_t;

    stage_t st [FDIV_LAT];
    stage_t st_in;

    // Resolves up to BPS quotient bits, MSB first; stages past the last bit pass through.
    function automatic stage_t div_step(input stage_t s, input int first_bit);
        stage_t r;
        r = s;
        for (int j = 0; j < BPS; j++) begin
            if (first_bit + j < QUO_W) begin
                if (r.rem >= {1'b0, r.dvs}) begin
                    r.quo = {r.quo[QUO_W-2:0], 1'b1};
                    r.rem = r.rem - {1'b0, r.dvs};
                end else begin
                    r.quo = {r.quo[QUO_W-2:0], 1'b0};
                end
                r.rem = {r.rem[MANT_W-1:0], 1'b0};
            end
        end
        return r;
    endfunction

    always_comb begin
        st_in     = '0;
        st_in.v   = input_valid;
        st_in.rem = {1'b0, dividend};
        st_in.dvs = divisor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FDIV_LAT; k++) st[k] <= '0;
        end else begin
            st[0] <= div_step(st_in, 0);
            for (int k = 1; k < FDIV_LAT; k++) st[k] <= div_step(st[k-1], k * BPS);
        end
    end

    assign out_valid = st[FDIV_LAT-1].v;
    assign quotient  = st[FDIV_LAT-1].quo;

endmodule

// File: rtl/fdiv_resp_fifo.sv
// Per-requester response FIFO: push/pop/clear with occupancy count; head reads 0 when empty.
module fdiv_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 30,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_eff;

    assign empty   = (count == '0);
    assign pop_eff = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_eff) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop_eff)      count <= count + 1'b1;
            else if (pop_eff && !push) count <= count - 1'b1;
        end
    end

    // Credit accounting upstream guarantees a slot for every returning result.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (int'(count) < DEPTH));

endmodule

// File: rtl/fdiv_mant_arbiter.sv
// Round-robin, credit-controlled sharing of one fdiv_mantissa among NREQ requesters.
// Optional FDIV_ARB_FLUSH_EN adds a flush port that kills all in-flight and queued results.
module fdiv_mant_arbiter
    import fdiv_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAGW  = FDIV_TAGW,
    parameter int DEPTH = 4,
    parameter int LAT   = FDIV_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef FDIV_ARB_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*MANT_W-1:0] req_dividend,
    input  logic [NREQ*MANT_W-1:0] req_divisor,
    input  logic [NREQ*TAGW-1:0]   req_tag,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [NREQ*QUO_W-1:0]  resp_quotient,
    output logic [NREQ*TAGW-1:0]   resp_tag
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = QUO_W + TAGW;

    logic              flush_act;
    logic [1:0]        rr_ptr;
    logic [NREQ-1:0]   eligible;
    logic              grant_any;
    logic [1:0]        grant_idx;
    logic [CW-1:0]     fifo_cnt [NREQ];
    logic [CW-1:0]     inflight [NREQ];
    logic [NREQ-1:0]   fifo_empty;
    logic [NREQ-1:0]   fifo_push;
    logic [NREQ-1:0]   fifo_pop;
    logic [MANT_W-1:0] sel_dividend;
    logic [MANT_W-1:0] sel_divisor;
    logic [TAGW-1:0]   sel_tag;
    fdiv_shadow_t      shadow [LAT];
    fdiv_shadow_t      shadow_in;
    fdiv_shadow_t      tail;
    logic              div_out_valid;
    logic [QUO_W-1:0]  div_quotient;

`ifdef FDIV_ARB_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && !flush_act
                          && (int'(fifo_cnt[i]) + int'(inflight[i]) < DEPTH);
        end
    end

    // Two passes: indices at/after rr_ptr first, then the wrapped-around ones.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && eligible[i] && ((p == 0) == (i >= int'(rr_ptr)))) begin
                    grant_any    = 1'b1;
                    grant_idx    = 2'(i);
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    assign sel_dividend = req_dividend[MANT_W*int'(grant_idx) +: MANT_W];
    assign sel_divisor  = req_divisor[MANT_W*int'(grant_idx) +: MANT_W];
    assign sel_tag      = req_tag[TAGW*int'(grant_idx) +: TAGW];

    always_comb begin
        shadow_in     = '0;
        shadow_in.v   = grant_any;
        shadow_in.id  = grant_idx;
        shadow_in.tag = sel_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (int'(grant_idx) == NREQ - 1) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) shadow[k] <= '0;
        end else if (flush_act) begin
            for (int k = 0; k < LAT; k++) shadow[k] <= '0;
        end else begin
            shadow[0] <= shadow_in;
            for (int k = 1; k < LAT; k++) shadow[k] <= shadow[k-1];
        end
    end

    assign tail = shadow[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) inflight[i] <= '0;
        end else if (flush_act) begin
            for (int i = 0; i < NREQ; i++) inflight[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({req_ready[i], fifo_push[i]})
                    2'b10:   inflight[i] <= inflight[i] + 1'b1;
                    2'b01:   inflight[i] <= inflight[i] - 1'b1;
                    default: inflight[i] <= inflight[i];
                endcase
            end
        end
    end

    fdiv_mantissa u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_valid (grant_any),
        .dividend    (sel_dividend),
        .divisor     (sel_divisor),
        .out_valid   (div_out_valid),
        .quotient    (div_quotient)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        logic [EW-1:0] head;

        assign fifo_push[gi] = tail.v && (tail.id == 2'(gi)) && !flush_act;
        assign fifo_pop[gi]  = resp_valid[gi] && resp_ready[gi];
        assign resp_valid[gi] = !fifo_empty[gi];
        assign resp_quotient[QUO_W*gi +: QUO_W] = head[EW-1 -: QUO_W];
        assign resp_tag[TAGW*gi +: TAGW]        = head[TAGW-1:0];

        fdiv_resp_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (flush_act),
            .push      (fifo_push[gi]),
            .push_data ({div_quotient, tail.tag}),
            .pop       (fifo_pop[gi]),
            .head      (head),
            .count     (fifo_cnt[gi]),
            .empty     (fifo_empty[gi])
        );
    end

`ifdef FDIV_ARB_FLUSH_EN
    // Killed operations still emerge from the divider; only the reverse direction must hold.
    a_tail_matches_div: assert property (@(posedge clk) disable iff (!rst_n)
        tail.v |-> div_out_valid);
`else
    a_tail_matches_div: assert property (@(posedge clk) disable iff (!rst_n)
        tail.v == div_out_valid);
`endif

endmodule
